// File: rtl/pipe_idu.sv
// RV32I decode stage: single-entry slot, flat decode, regfile read, RAW scoreboard. Optional macro: IDU_WB_BYPASS_EN.
// Latency: 1 cycle from fetch handshake to earliest id_valid_o; back-to-back issue when no hazard.
// Backpressure: id_ready_o = !slot_valid | id_fire; the slot holds while EX stalls or a source is busy.
module pipe_idu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_inst_i,
    output logic        id_ready_o,
    output logic [4:0]  rf_raddr1_o,
    output logic [4:0]  rf_raddr2_o,
    input  logic [31:0] rf_rdata1_i,
    input  logic [31:0] rf_rdata2_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        id_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_rs1_val_o,
    output logic [31:0] id_rs2_val_o,
    output logic [31:0] id_imm_o,
    output logic [4:0]  id_rd_o,
    output logic        id_rd_wen_o,
    output logic [3:0]  id_opclass_o,
    output logic [2:0]  id_funct3_o,
    output logic        id_alt_o,
    output logic        id_illegal_o
);

    localparam logic [3:0] OC_OP     = 4'd0;
    localparam logic [3:0] OC_OPIMM  = 4'd1;
    localparam logic [3:0] OC_LOAD   = 4'd2;
    localparam logic [3:0] OC_STORE  = 4'd3;
    localparam logic [3:0] OC_BRANCH = 4'd4;
    localparam logic [3:0] OC_JAL    = 4'd5;
    localparam logic [3:0] OC_JALR   = 4'd6;
    localparam logic [3:0] OC_LUI    = 4'd7;
    localparam logic [3:0] OC_AUIPC  = 4'd8;
    localparam logic [3:0] OC_SYSTEM = 4'd9;
    localparam logic [3:0] OC_ILL    = 4'd15;

    logic             slot_valid;
    logic [31:0]      inst_q;
    logic [31:0]      pc_q;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic        if_fire;
    logic        id_fire;
    logic        hazard;
    logic        rs1_used;
    logic        rs2_used;
    logic        writes_rd;
    logic        legal;
    logic        byp1;
    logic        byp2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = inst_q[6:0];
    assign f3     = inst_q[14:12];
    assign f7     = inst_q[31:25];
    assign rs1    = inst_q[19:15];
    assign rs2    = inst_q[24:20];

    assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
    assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign imm_u = {inst_q[31:12], 12'b0};
    assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

    always_comb begin
        id_opclass_o = OC_ILL;
        id_imm_o     = 32'd0;
        id_alt_o     = 1'b0;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        writes_rd    = 1'b0;
        legal        = 1'b1;
        case (opcode)
            7'b0110011: begin
                id_opclass_o = OC_OP;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                writes_rd    = 1'b1;
                id_alt_o     = inst_q[30];
                legal        = (f7 == 7'b0000000) ||
                               (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            7'b0010011: begin
                id_opclass_o = OC_OPIMM;
                id_imm_o     = imm_i;
                rs1_used     = 1'b1;
                writes_rd    = 1'b1;
                if (f3 == 3'b001) begin
                    id_alt_o = inst_q[30];
                    legal    = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    id_alt_o = inst_q[30];
                    legal    = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                end
            end
            7'b0000011: begin
                id_opclass_o = OC_LOAD;
                id_imm_o     = imm_i;
                rs1_used     = 1'b1;
                writes_rd    = 1'b1;
                legal        = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            7'b0100011: begin
                id_opclass_o = OC_STORE;
                id_imm_o     = imm_s;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                legal        = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            end
            7'b1100011: begin
                id_opclass_o = OC_BRANCH;
                id_imm_o     = imm_b;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                legal        = (f3 != 3'b010) && (f3 != 3'b011);
            end
            7'b1101111: begin
                id_opclass_o = OC_JAL;
                id_imm_o     = imm_j;
                writes_rd    = 1'b1;
            end
            7'b1100111: begin
                id_opclass_o = OC_JALR;
                id_imm_o     = imm_i;
                rs1_used     = 1'b1;
                writes_rd    = 1'b1;
                legal        = (f3 == 3'b000);
            end
            7'b0110111: begin
                id_opclass_o = OC_LUI;
                id_imm_o     = imm_u;
                writes_rd    = 1'b1;
            end
            7'b0010111: begin
                id_opclass_o = OC_AUIPC;
                id_imm_o     = imm_u;
                writes_rd    = 1'b1;
            end
            7'b1110011: begin
                // funct3==0 is ecall/ebreak (no rd); the rest are CSR ops
                id_opclass_o = OC_SYSTEM;
                id_imm_o     = imm_i;
                writes_rd    = (f3 != 3'b000);
                legal        = (f3 != 3'b100);
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            id_opclass_o = OC_ILL;
            id_imm_o     = 32'd0;
            id_alt_o     = 1'b0;
            rs1_used     = 1'b0;
            rs2_used     = 1'b0;
            writes_rd    = 1'b0;
        end
    end

`ifdef IDU_WB_BYPASS_EN
    assign byp1         = wb_valid_i && (wb_rd_i == rs1) && (rs1 != 5'd0);
    assign byp2         = wb_valid_i && (wb_rd_i == rs2) && (rs2 != 5'd0);
    assign id_rs1_val_o = byp1 ? wb_data_i : rf_rdata1_i;
    assign id_rs2_val_o = byp2 ? wb_data_i : rf_rdata2_i;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data_i;
    assign byp1           = 1'b0;
    assign byp2           = 1'b0;
    assign id_rs1_val_o   = rf_rdata1_i;
    assign id_rs2_val_o   = rf_rdata2_i;
`endif

    assign hazard = slot_valid &&
                    ((rs1_used && busy_q[rs1] && !byp1) ||
                     (rs2_used && busy_q[rs2] && !byp2));

    assign id_illegal_o = !legal;
    assign id_rd_o      = inst_q[11:7];
    assign id_rd_wen_o  = writes_rd && (inst_q[11:7] != 5'd0);
    assign id_funct3_o  = f3;
    assign id_pc_o      = pc_q;
    assign rf_raddr1_o  = rs1;
    assign rf_raddr2_o  = rs2;

    assign id_valid_o = slot_valid && !hazard && !flush_i;
    assign id_fire    = id_valid_o && ex_ready_i;
    assign id_ready_o = !slot_valid || id_fire;
    assign if_fire    = if_valid_i && id_ready_o && !flush_i;

    // set after clear so an issuing writer wins over a same-index retire
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i && wb_rd_i != 5'd0)
            busy_d[wb_rd_i] = 1'b0;
        if (id_fire && id_rd_wen_o)
            busy_d[id_rd_o] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid <= 1'b0;
            inst_q     <= 32'd0;
            pc_q       <= RESET_PC;
            busy_q     <= '0;
        end else begin
            busy_q <= busy_d;
            if (if_fire) begin
                slot_valid <= 1'b1;
                inst_q     <= if_inst_i;
                pc_q       <= if_pc_i;
            end else if (id_fire || flush_i) begin
                slot_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_idu.sv
// Directed bench for pipe_idu: issue, RAW stall/release, backpressure, flush, illegal, jal, async reset.
module tb_pipe_idu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        id_ready_o;
    logic [4:0]  rf_raddr1_o;
    logic [4:0]  rf_raddr2_o;
    logic [31:0] rf_rdata1_i;
    logic [31:0] rf_rdata2_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        id_valid_o;
    logic        ex_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_rs1_val_o;
    logic [31:0] id_rs2_val_o;
    logic [31:0] id_imm_o;
    logic [4:0]  id_rd_o;
    logic        id_rd_wen_o;
    logic [3:0]  id_opclass_o;
    logic [2:0]  id_funct3_o;
    logic        id_alt_o;
    logic        id_illegal_o;

    int n_vec = 0;
    int n_err = 0;

    pipe_idu dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
        .id_ready_o(id_ready_o),
        .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
        .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .id_valid_o(id_valid_o), .ex_ready_i(ex_ready_i),
        .id_pc_o(id_pc_o), .id_rs1_val_o(id_rs1_val_o), .id_rs2_val_o(id_rs2_val_o),
        .id_imm_o(id_imm_o), .id_rd_o(id_rd_o), .id_rd_wen_o(id_rd_wen_o),
        .id_opclass_o(id_opclass_o), .id_funct3_o(id_funct3_o),
        .id_alt_o(id_alt_o), .id_illegal_o(id_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // register file stand-in: data encodes the port and the address read
    assign rf_rdata1_i = 32'hA000_0000 | {27'd0, rf_raddr1_o};
    assign rf_rdata2_i = 32'hB000_0000 | {27'd0, rf_raddr2_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid_i = v;
        if_pc_i    = pc;
        if_inst_i  = inst;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid_i = v;
        wb_rd_i    = rd;
        wb_data_i  = d;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b1;
        offer(1'b0, 32'd0, 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        #2;
        chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, id_ready_o}, 32'd1);
        chk("rst_busy", dut.busy_q, 32'd0);
        chk("rst_pc", id_pc_o, 32'h8000_0000);
        chk("rst_illegal", {31'd0, id_illegal_o}, 32'd1);
        cyc(); cyc();
        rst_i = 1'b0;

        // addi x1,x0,5
        cyc();
        offer(1'b1, 32'h8000_0000, 32'h0050_0093);
        #1 chk("c0_ready", {31'd0, id_ready_o}, 32'd1);
        chk("c0_valid", {31'd0, id_valid_o}, 32'd0);

        // add x2,x1,x1 offered while addi issues
        cyc();
        offer(1'b1, 32'h8000_0004, 32'h0010_8133);
        #1 chk("addi_valid", {31'd0, id_valid_o}, 32'd1);
        chk("addi_opclass", {28'd0, id_opclass_o}, 32'd1);
        chk("addi_imm", id_imm_o, 32'd5);
        chk("addi_rd", {27'd0, id_rd_o}, 32'd1);
        chk("addi_rdwen", {31'd0, id_rd_wen_o}, 32'd1);
        chk("addi_pc", id_pc_o, 32'h8000_0000);
        chk("addi_ready", {31'd0, id_ready_o}, 32'd1);

        cyc();
        offer(1'b0, 32'd0, 32'd0);
        #1 chk("raw_busy", dut.busy_q, 32'h0000_0002);
        chk("raw_valid", {31'd0, id_valid_o}, 32'd0);
        chk("raw_ready", {31'd0, id_ready_o}, 32'd0);
        chk("add_opclass", {28'd0, id_opclass_o}, 32'd0);
        chk("add_raddr1", {27'd0, rf_raddr1_o}, 32'd1);
        chk("add_raddr2", {27'd0, rf_raddr2_o}, 32'd1);

        cyc();
        wb(1'b1, 5'd1, 32'h1234_5678);
`ifdef IDU_WB_BYPASS_EN
        #1 chk("byp_valid", {31'd0, id_valid_o}, 32'd1);
        chk("byp_rs1", id_rs1_val_o, 32'h1234_5678);
        chk("byp_rs2", id_rs2_val_o, 32'h1234_5678);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
`else
        #1 chk("nobyp_stall", {31'd0, id_valid_o}, 32'd0);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
        #1 chk("nobyp_busy", dut.busy_q, 32'd0);
        chk("nobyp_valid", {31'd0, id_valid_o}, 32'd1);
        chk("nobyp_rs1", id_rs1_val_o, 32'hA000_0001);
        chk("nobyp_rs2", id_rs2_val_o, 32'hB000_0001);
        cyc();
`endif
        #1 chk("add_busy", dut.busy_q, 32'h0000_0004);
        chk("add_gone", {31'd0, id_valid_o}, 32'd0);

        // backpressure: three independent addis, EX stalled; also retire x2
        cyc();
        ex_ready_i = 1'b0;
        offer(1'b1, 32'h0000_0100, 32'h0010_0193);
        wb(1'b1, 5'd2, 32'd0);
        #1 chk("bp_ready0", {31'd0, id_ready_o}, 32'd1);
        cyc();
        offer(1'b1, 32'h0000_0104, 32'h0020_0213);
        wb(1'b0, 5'd0, 32'd0);
        #1 chk("bp_valid", {31'd0, id_valid_o}, 32'd1);
        chk("bp_ready1", {31'd0, id_ready_o}, 32'd0);
        chk("bp_busy", dut.busy_q, 32'd0);
        cyc();
        #1 chk("bp_hold_pc", id_pc_o, 32'h0000_0100);
        chk("bp_hold_imm", id_imm_o, 32'd1);
        chk("bp_hold_ready", {31'd0, id_ready_o}, 32'd0);
        cyc();
        ex_ready_i = 1'b1;
        #1 chk("rel_ready", {31'd0, id_ready_o}, 32'd1);
        chk("rel_pc0", id_pc_o, 32'h0000_0100);
        cyc();
        offer(1'b1, 32'h0000_0108, 32'h0030_0293);
        #1 chk("rel_valid1", {31'd0, id_valid_o}, 32'd1);
        chk("rel_pc1", id_pc_o, 32'h0000_0104);
        chk("rel_imm1", id_imm_o, 32'd2);
        chk("rel_busy1", dut.busy_q, 32'h0000_0008);
        cyc();
        offer(1'b1, 32'h0000_010C, 32'h0020_8463);
        #1 chk("rel_valid2", {31'd0, id_valid_o}, 32'd1);
        chk("rel_pc2", id_pc_o, 32'h0000_0108);
        chk("rel_rd2", {27'd0, id_rd_o}, 32'd5);

        // flush while beq held; offered fetch must be ignored
        cyc();
        flush_i = 1'b1;
        offer(1'b1, 32'h0000_0200, 32'h0010_0193);
        #1 chk("fl_valid", {31'd0, id_valid_o}, 32'd0);
        chk("fl_ready", {31'd0, id_ready_o}, 32'd0);
        chk("beq_opclass", {28'd0, id_opclass_o}, 32'd4);
        chk("beq_imm", id_imm_o, 32'd8);
        chk("fl_busy", dut.busy_q, 32'h0000_0038);
        cyc();
        flush_i = 1'b0;
        offer(1'b0, 32'd0, 32'd0);
        #1 chk("fl_empty", {31'd0, id_valid_o}, 32'd0);
        chk("fl_ready_after", {31'd0, id_ready_o}, 32'd1);
        chk("fl_pc_kept", id_pc_o, 32'h0000_010C);
        chk("fl_busy_after", dut.busy_q, 32'h0000_0038);

        // illegal word still issues, no scoreboard update
        offer(1'b1, 32'h0000_0300, 32'hFFFF_FFFF);
        cyc();
        offer(1'b0, 32'd0, 32'd0);
        #1 chk("ill_valid", {31'd0, id_valid_o}, 32'd1);
        chk("ill_flag", {31'd0, id_illegal_o}, 32'd1);
        chk("ill_opclass", {28'd0, id_opclass_o}, 32'd15);
        chk("ill_rdwen", {31'd0, id_rd_wen_o}, 32'd0);

        // jal x1,-4 while x3 retires
        cyc();
        offer(1'b1, 32'h0000_0400, 32'hFFDF_F0EF);
        wb(1'b1, 5'd3, 32'd0);
        #1 chk("ill_busy", dut.busy_q, 32'h0000_0038);
        chk("ill_issued", {31'd0, id_valid_o}, 32'd0);
        cyc();
        offer(1'b0, 32'd0, 32'd0);
        wb(1'b1, 5'd1, 32'hDEAD_BEEF);
        #1 chk("jal_valid", {31'd0, id_valid_o}, 32'd1);
        chk("jal_opclass", {28'd0, id_opclass_o}, 32'd5);
        chk("jal_imm", id_imm_o, 32'hFFFF_FFFC);
        chk("jal_rd", {27'd0, id_rd_o}, 32'd1);
        chk("jal_rdwen", {31'd0, id_rd_wen_o}, 32'd1);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
        #1 chk("setwins_busy", dut.busy_q, 32'h0000_0032);

        // asynchronous reset with an instruction held
        offer(1'b1, 32'h0000_0500, 32'h0010_0193);
        cyc();
        offer(1'b0, 32'd0, 32'd0);
        #1 chk("pre_rst_valid", {31'd0, id_valid_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1 chk("arst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("arst_ready", {31'd0, id_ready_o}, 32'd1);
        chk("arst_busy", dut.busy_q, 32'd0);
        chk("arst_pc", id_pc_o, 32'h8000_0000);
        cyc();
        rst_i = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_idu.md
Name: pipe_idu

Overview:
- Decode stage between the instruction-fetch stage and the execute stage.
- Captures one fetched {pc, inst} per handshake into a single-entry stage register, decodes RV32I into a flat control bundle, and reads the register file.
- Stalls on RAW hazards with a 32-entry busy-register scoreboard that is cleared by writeback.
- Presents a valid/ready handshake both upstream and downstream.

Parameters:
- RESET_PC, 32'h80000000, reset value of the pc_q payload register (debug visibility only).
- NREGS, 32, scoreboard depth; index 0 is never marked busy.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  kill the held instruction (redirect from EX/WB)
- if_valid_i  in  1  fetch stage offers an instruction
- if_pc_i  in  32  pc of the offered instruction
- if_inst_i  in  32  offered instruction word
- id_ready_o  out  1  stage can accept this cycle
- rf_raddr1_o  out  5  regfile read address rs1 (inst[19:15])
- rf_raddr2_o  out  5  regfile read address rs2 (inst[24:20])
- rf_rdata1_i  in  32  combinational regfile read data 1
- rf_rdata2_i  in  32  combinational regfile read data 2
- wb_valid_i  in  1  a register write retires this cycle
- wb_rd_i  in  5  destination of the retiring write
- wb_data_i  in  32  retiring write data (used only with the optional feature)
- id_valid_o  out  1  decoded instruction available to EX
- ex_ready_i  in  1  EX accepts
- id_pc_o  out  32  held pc
- id_rs1_val_o  out  32  operand 1
- id_rs2_val_o  out  32  operand 2
- id_imm_o  out  32  sign-extended immediate
- id_rd_o  out  5  destination register
- id_rd_wen_o  out  1  instruction writes rd (0 if rd==0)
- id_opclass_o  out  4  0 OP, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 15 illegal
- id_funct3_o  out  3  inst[14:12]
- id_alt_o  out  1  inst[30] for OP, and for OP-IMM shifts; 0 otherwise
- id_illegal_o  out  1  opcode/funct not decodable

Behaviour:
- Reset state:
  - slot_valid=0, busy vector=0, inst_q=0, pc_q=RESET_PC.
  - id_valid_o=0, id_ready_o=1.
  - All decoded outputs are derived from inst_q=0, which decodes as illegal; they are don't-care while id_valid_o=0.
- Handshake:
  - if_fire = if_valid_i & id_ready_o & !flush_i; id_fire = id_valid_o & ex_ready_i.
  - id_ready_o = !slot_valid | id_fire.
  - On if_fire, capture pc/inst and set slot_valid; otherwise clear slot_valid on id_fire.
  - Back-to-back operation is allowed: one instruction per cycle with no bubbles when there is no hazard.
- Decode:
  - Purely combinational from inst_q, so decode outputs are valid in the cycle after capture; latency is 1 cycle from if_fire to the earliest id_valid_o.
- Immediates:
  - I: inst[31:20]; S: {inst[31:25], inst[11:7]}; B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}; U: {inst[31:12], 12'b0}; J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All are sign-extended to 32 bits.
- Source usage:
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
- Scoreboard:
  - hazard = slot_valid & ((rs1_used & busy[rs1]) | (rs2_used & busy[rs2])).
  - id_valid_o = slot_valid & !hazard & !flush_i.
  - On id_fire with id_rd_wen_o, set busy[rd]. On wb_valid_i with wb_rd_i != 0, clear busy[wb_rd_i].
  - If set and clear hit the same index in the same cycle, set wins.
  - busy[0] is always 0.
- Flush:
  - Clears slot_valid next cycle; id_valid_o is masked in the flush cycle itself.
  - Does not clear the busy vector, because older in-flight writers still retire.
  - if_fire is blocked during flush.
- Illegal instructions:
  - id_illegal_o=1, id_opclass_o=15, id_rd_wen_o=0.
  - The instruction still issues so that EX raises the trap; no scoreboard update.
- SYSTEM (ecall/ebreak/csr): decoded with opclass 9, rd_wen per rd!=0 for CSR ops.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); the held instruction is lost.

Optional Feature:
- IDU_WB_BYPASS_EN.
- Defined:
  - A source with wb_valid_i & wb_rd_i==rs & rs!=0 is treated as not busy, and its operand is taken from wb_data_i instead of rf_rdata.
  - Exception: when id_fire sets the same rd in that cycle, the bypass applies only to the current instruction's sources.
- Undefined:
  - wb_data_i is ignored. A source matching the retiring write stalls until the cycle after busy clears, and the regfile supplies the data.

Test Plan:
- Reset, then fetch addi x1,x0,5 (0x00500093) at pc 0x80000000 -> next cycle id_valid_o=1, opclass=1, imm=5, rd=1, rd_wen=1; with ex_ready_i=1, busy[1] is set.
- Follow with add x2,x1,x1 (0x00108133) and no writeback -> id_valid_o stays 0. Then wb_valid_i=1, wb_rd_i=1:
  - Bypass defined: issues the same cycle with rs1/rs2 = wb_data_i.
  - Bypass undefined: issues the next cycle.
- Hold ex_ready_i=0 with 3 non-dependent instructions offered -> id_ready_o=0, slot held, pc/inst stable. Release -> one issue per cycle, no bubbles.
- flush_i while the slot holds beq (0x00208463) -> id_valid_o=0 in that cycle, slot empty next cycle, busy vector unchanged, if_valid_i ignored during the flush.
- Offer 0xFFFFFFFF -> id_illegal_o=1, opclass=15, rd_wen=0, issues normally, no busy bit set.
- jal x1,-4 (0xFFDFF0EF) -> imm=0xFFFFFFFC, opclass=5. Same-cycle issue setting busy[1] with writeback clearing busy[1] -> busy[1] remains 1.
